// File: rtl/sap_1_datapath_top.sv
// SAP-1 datapath: PC, MAR, 16x8 RAM, IR, A, B, ALU and OUT around a single multiplexed W bus.
// Optional macro SAP_1_DATAPATH_FLAGS_EN adds registered Carry/Zero flags from the ALU.
module sap_1_datapath_top #(
   parameter logic [3:0] PC_RESET = 4'h0
) (
   input  logic       Clk,
   input  logic       Clr,
   input  logic       Cp,
   input  logic       Ep,
   input  logic       LMbar,
   input  logic       CEbar,
   input  logic       LIbar,
   input  logic       EIbar,
   input  logic       LAbar,
   input  logic       EA,
   input  logic       SU,
   input  logic       EU,
   input  logic       LBbar,
   input  logic       LObar,
   input  logic       Prog_we,
   input  logic [3:0] Prog_addr,
   input  logic [7:0] Prog_data,
   output logic [3:0] opcode,
   output logic [7:0] Out_port,
   output logic [7:0] W_bus,
`ifdef SAP_1_DATAPATH_FLAGS_EN
   output logic       Carry,
   output logic       Zero,
`endif
   output logic       Bus_conflict
);

   logic [3:0] pc;
   logic [3:0] mar;
   logic [7:0] ram [16];
   logic [7:0] ir;
   logic [7:0] a_reg;
   logic [7:0] b_reg;
   logic [7:0] out_reg;
   logic [7:0] b_op;
   logic [8:0] alu_sum;
   logic [4:0] drivers;

   // Subtraction is A + ~B + 1; bit 8 is the adder carry in both modes.
   assign b_op    = SU ? ~b_reg : b_reg;
   assign alu_sum = {1'b0, a_reg} + {1'b0, b_op} + {8'h00, SU};

   always_comb begin
      W_bus = 8'h00;
      if (Ep)          W_bus = {4'h0, pc};
      else if (!CEbar) W_bus = ram[mar];
      else if (!EIbar) W_bus = {4'h0, ir[3:0]};
      else if (EA)     W_bus = a_reg;
      else if (EU)     W_bus = alu_sum[7:0];
   end

   assign drivers      = {Ep, ~CEbar, ~EIbar, EA, EU};
   assign Bus_conflict = (drivers & (drivers - 5'd1)) != 5'd0;

   // RAM programming ignores Clr so a loaded program survives reset.
   always_ff @(posedge Clk) begin
      if (Prog_we) ram[Prog_addr] <= Prog_data;
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         pc      <= PC_RESET;
         mar     <= 4'h0;
         ir      <= 8'h00;
         a_reg   <= 8'h00;
         b_reg   <= 8'h00;
         out_reg <= 8'h00;
      end else begin
         if (Cp)     pc      <= pc + 4'h1;
         if (!LMbar) mar     <= W_bus[3:0];
         if (!LIbar) ir      <= W_bus;
         if (!LAbar) a_reg   <= W_bus;
         if (!LBbar) b_reg   <= W_bus;
         if (!LObar) out_reg <= W_bus;
      end
   end

`ifdef SAP_1_DATAPATH_FLAGS_EN
   always_ff @(posedge Clk) begin
      if (Clr) begin
         Carry <= 1'b0;
         Zero  <= 1'b0;
      end else if (!LAbar && EU) begin
         Carry <= alu_sum[8];
         Zero  <= (alu_sum[7:0] == 8'h00);
      end
   end
`endif

   assign opcode   = ir[7:4];
   assign Out_port = out_reg;

endmodule

// File: tb/tb_sap_1_datapath_top.sv
// Directed bench for sap_1_datapath_top; internal registers are observed by driving them onto W_bus.
module tb_sap_1_datapath_top;

   logic       Clk = 1'b0;
   logic       Clr, Cp, Ep, LMbar, CEbar, LIbar, EIbar, LAbar, EA, SU, EU, LBbar, LObar, Prog_we;
   logic [3:0] Prog_addr;
   logic [7:0] Prog_data;
   logic [3:0] opcode;
   logic [7:0] Out_port;
   logic [7:0] W_bus;
   logic       Bus_conflict;
`ifdef SAP_1_DATAPATH_FLAGS_EN
   logic       Carry, Zero;
`endif

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   sap_1_datapath_top dut (
      .Clk(Clk), .Clr(Clr), .Cp(Cp), .Ep(Ep), .LMbar(LMbar), .CEbar(CEbar),
      .LIbar(LIbar), .EIbar(EIbar), .LAbar(LAbar), .EA(EA), .SU(SU), .EU(EU),
      .LBbar(LBbar), .LObar(LObar), .Prog_we(Prog_we), .Prog_addr(Prog_addr),
      .Prog_data(Prog_data), .opcode(opcode), .Out_port(Out_port), .W_bus(W_bus),
`ifdef SAP_1_DATAPATH_FLAGS_EN
      .Carry(Carry), .Zero(Zero),
`endif
      .Bus_conflict(Bus_conflict)
   );

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      Clr = 0; Cp = 0; Ep = 0; LMbar = 1; CEbar = 1; LIbar = 1; EIbar = 1;
      LAbar = 1; EA = 0; SU = 0; EU = 0; LBbar = 1; LObar = 1;
      Prog_we = 0; Prog_addr = 4'h0; Prog_data = 8'h00;
   endtask

   // MAR is kept at 0, so RAM[0] is the path for loading arbitrary bytes.
   task automatic prog0(input logic [7:0] v);
      idle(); Prog_we = 1; Prog_addr = 4'h0; Prog_data = v;
      tick(); idle();
   endtask

   task automatic do_reset();
      idle(); Clr = 1; tick(); idle();
   endtask

   task automatic test_reset();
      prog0(8'h5A);
      idle(); Clr = 1; Cp = 1; LAbar = 0; LObar = 0; LIbar = 0; CEbar = 0;
      tick(); idle(); #1;
      checks++; if (opcode !== 4'h0) begin errors++; $display("FAIL reset_opcode got %h exp 0", opcode); end
      checks++; if (Out_port !== 8'h00) begin errors++; $display("FAIL reset_out got %h exp 00", Out_port); end
      checks++; if (W_bus !== 8'h00 || Bus_conflict !== 1'b0) begin errors++; $display("FAIL idle_bus got %h/%b exp 00/0", W_bus, Bus_conflict); end
      Ep = 1; #1;
      checks++; if (W_bus !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", W_bus); end
      idle(); EA = 1; #1;
      checks++; if (W_bus !== 8'h00) begin errors++; $display("FAIL reset_a got %h exp 00", W_bus); end
      idle(); CEbar = 0; #1;
      checks++; if (W_bus !== 8'h5A) begin errors++; $display("FAIL ram_kept got %h exp 5a", W_bus); end
`ifdef SAP_1_DATAPATH_FLAGS_EN
      checks++; if (Carry !== 1'b0 || Zero !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", Carry, Zero); end
`endif
      idle();
   endtask

   task automatic test_fetch();
      do_reset();
      prog0(8'h09);
      Ep = 1; LMbar = 0; tick(); idle();
      CEbar = 0; LIbar = 0; tick(); idle();
      checks++; if (opcode !== 4'h0) begin errors++; $display("FAIL fetch_opcode got %h exp 0", opcode); end
      EIbar = 0; #1;
      checks++; if (W_bus !== 8'h09) begin errors++; $display("FAIL fetch_operand got %h exp 09", W_bus); end
      idle();
      prog0(8'hA7);
      CEbar = 0; LIbar = 0; tick(); idle();
      checks++; if (opcode !== 4'hA) begin errors++; $display("FAIL fetch_opcode2 got %h exp a", opcode); end
      EIbar = 0; LObar = 0; tick(); idle();
      checks++; if (Out_port !== 8'h07) begin errors++; $display("FAIL out_load got %h exp 07", Out_port); end
   endtask

   task automatic test_alu();
      do_reset();
      prog0(8'h05); CEbar = 0; LAbar = 0; tick(); idle();
      prog0(8'h03); CEbar = 0; LBbar = 0; tick(); idle();
      SU = 1; EU = 1; LAbar = 0; #1;
      checks++; if (W_bus !== 8'h02) begin errors++; $display("FAIL alu_sub_bus got %h exp 02", W_bus); end
      tick(); idle();
      EA = 1; #1;
      checks++; if (W_bus !== 8'h02) begin errors++; $display("FAIL alu_sub_a got %h exp 02", W_bus); end
`ifdef SAP_1_DATAPATH_FLAGS_EN
      checks++; if (Carry !== 1'b1 || Zero !== 1'b0) begin errors++; $display("FAIL flags_sub got %b%b exp 10", Carry, Zero); end
`endif
      idle();
      prog0(8'hFF); CEbar = 0; LAbar = 0; tick(); idle();
      prog0(8'h01); CEbar = 0; LBbar = 0; tick(); idle();
      SU = 0; EU = 1; LAbar = 0; tick(); idle();
      EA = 1; #1;
      checks++; if (W_bus !== 8'h00) begin errors++; $display("FAIL alu_add_wrap got %h exp 00", W_bus); end
`ifdef SAP_1_DATAPATH_FLAGS_EN
      checks++; if (Carry !== 1'b1 || Zero !== 1'b1) begin errors++; $display("FAIL flags_add got %b%b exp 11", Carry, Zero); end
`endif
      idle();
      // A=00, B=01: 0 - 1 wraps to FF with no carry
      SU = 1; EU = 1; #1;
      checks++; if (W_bus !== 8'hFF) begin errors++; $display("FAIL alu_sub_wrap got %h exp ff", W_bus); end
      LAbar = 0; tick(); idle();
`ifdef SAP_1_DATAPATH_FLAGS_EN
      checks++; if (Carry !== 1'b0 || Zero !== 1'b0) begin errors++; $display("FAIL flags_borrow got %b%b exp 00", Carry, Zero); end
`endif
      EA = 1; LAbar = 0; tick(); idle();
      EA = 1; #1;
      checks++; if (W_bus !== 8'hFF) begin errors++; $display("FAIL a_self_reload got %h exp ff", W_bus); end
      idle();
   endtask

   task automatic test_pc_wrap();
      do_reset();
      Cp = 1;
      for (int i = 0; i < 17; i++) tick();
      idle(); Ep = 1; #1;
      checks++; if (W_bus !== 8'h01) begin errors++; $display("FAIL pc_wrap got %h exp 01", W_bus); end
      Cp = 1; LAbar = 0; #1;
      checks++; if (W_bus !== 8'h01) begin errors++; $display("FAIL pc_pre_inc got %h exp 01", W_bus); end
      tick(); idle(); Ep = 1; #1;
      checks++; if (W_bus !== 8'h02) begin errors++; $display("FAIL pc_post_inc got %h exp 02", W_bus); end
      idle(); EA = 1; #1;
      checks++; if (W_bus !== 8'h01) begin errors++; $display("FAIL a_from_pc got %h exp 01", W_bus); end
      idle();
   endtask

   task automatic test_conflict();
      do_reset();
      Cp = 1; tick(); tick(); tick(); idle();
      prog0(8'hAA); CEbar = 0; LAbar = 0; tick(); idle();
      Ep = 1; EA = 1; #1;
      checks++; if (W_bus !== 8'h03 || Bus_conflict !== 1'b1) begin errors++; $display("FAIL conflict_ep_ea got %h/%b exp 03/1", W_bus, Bus_conflict); end
      idle(); EA = 1; EU = 1; #1;
      checks++; if (W_bus !== 8'hAA || Bus_conflict !== 1'b1) begin errors++; $display("FAIL conflict_ea_eu got %h/%b exp aa/1", W_bus, Bus_conflict); end
      idle(); EIbar = 0; EU = 1; #1;
      checks++; if (W_bus !== 8'h00 || Bus_conflict !== 1'b1) begin errors++; $display("FAIL conflict_ei_eu got %h/%b exp 00/1", W_bus, Bus_conflict); end
      idle(); EA = 1; #1;
      checks++; if (W_bus !== 8'hAA || Bus_conflict !== 1'b0) begin errors++; $display("FAIL single_driver got %h/%b exp aa/0", W_bus, Bus_conflict); end
      idle();
   endtask

   task automatic test_back_to_back();
      do_reset();
      prog0(8'h11);
      Prog_we = 1; Prog_addr = 4'h0; Prog_data = 8'h22; CEbar = 0; LAbar = 0; LBbar = 0; #1;
      checks++; if (W_bus !== 8'h11) begin errors++; $display("FAIL ram_old_read got %h exp 11", W_bus); end
      tick(); idle();
      CEbar = 0; #1;
      checks++; if (W_bus !== 8'h22) begin errors++; $display("FAIL ram_new_read got %h exp 22", W_bus); end
      // A=11 and B=11 captured together; A+B=22 shows B got the same bus value
      idle(); EU = 1; #1;
      checks++; if (W_bus !== 8'h22) begin errors++; $display("FAIL multi_load got %h exp 22", W_bus); end
      idle();
      Prog_we = 1; Prog_addr = 4'h5; Prog_data = 8'h77; Clr = 1; tick(); idle();
      Prog_addr = 4'h5; Ep = 1; Cp = 1; tick(); idle();
      Ep = 1; LMbar = 0; tick(); idle();
      checks++; if (opcode !== 4'h0) begin errors++; $display("FAIL clr_opcode got %h exp 0", opcode); end
      Cp = 1; for (int i = 0; i < 4; i++) tick(); idle();
      Ep = 1; LMbar = 0; tick(); idle();
      CEbar = 0; #1;
      checks++; if (W_bus !== 8'h77) begin errors++; $display("FAIL prog_during_clr got %h exp 77", W_bus); end
      idle();
   endtask

   initial begin
      idle();
      tick();
      test_reset();
      test_fetch();
      test_alu();
      test_pc_wrap();
      test_conflict();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sap_1_datapath_top.md
SAP_1_DATAPATH_TOP -- requirements
Module: sap_1_datapath_top

Interface
REQ-001 The block SHALL have parameter PC_RESET, default 4'h0, giving the program counter value loaded on reset.
REQ-002 The block SHALL have port Clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port Clr, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port Cp, input, 1, increment program counter.
REQ-005 The block SHALL have port Ep, input, 1, drive program counter onto W bus.
REQ-006 The block SHALL have port LMbar, input, 1, active-low load MAR from W bus.
REQ-007 The block SHALL have port CEbar, input, 1, active-low drive RAM[MAR] onto W bus.
REQ-008 The block SHALL have port LIbar, input, 1, active-low load instruction register from W bus.
REQ-009 The block SHALL have port EIbar, input, 1, active-low drive IR[3:0] onto W bus.
REQ-010 The block SHALL have port LAbar, input, 1, active-low load accumulator from W bus.
REQ-011 The block SHALL have port EA, input, 1, drive accumulator onto W bus.
REQ-012 The block SHALL have port SU, input, 1, ALU mode: 0 = A+B, 1 = A-B.
REQ-013 The block SHALL have port EU, input, 1, drive ALU result onto W bus.
REQ-014 The block SHALL have port LBbar, input, 1, active-low load B register from W bus.
REQ-015 The block SHALL have port LObar, input, 1, active-low load output register from W bus.
REQ-016 The block SHALL have port Prog_we, input, 1, RAM programming write strobe.
REQ-017 The block SHALL have ports Prog_addr, input, 4, and Prog_data, input, 8, RAM programming address and data.
REQ-018 The block SHALL have port opcode, output, 4 (bits [7:4]), IR[7:4] to the controller-sequencer.
REQ-019 The block SHALL have port Out_port, output, 8, output register contents.
REQ-020 The block SHALL have port W_bus, output, 8, current W bus value for observation.
REQ-021 The block SHALL have port Bus_conflict, output, 1, high when more than one bus driver is enabled.

Function
REQ-022 Internal state SHALL be PC (4b), MAR (4b), RAM (16x8), IR (8b), A (8b), B (8b), OUT (8b); no tristates.
REQ-023 W bus SHALL be combinational: Ep -> {4'h0,PC}; CEbar=0 -> RAM[MAR]; EIbar=0 -> {4'h0,IR[3:0]}; EA -> A; EU -> ALU; none -> 8'h00.
REQ-024 With multiple drivers enabled, priority SHALL be Ep > CEbar > EIbar > EA > EU and Bus_conflict SHALL be 1 in that same cycle.
REQ-025 ALU SHALL be combinational, 8-bit modulo 256: A+B when SU=0, A+~B+1 when SU=1; no carry out except per REQ-033.
REQ-026 Each asserted load SHALL capture the W bus value at the rising edge of that cycle (latency 1 clock); several loads in one cycle SHALL all capture the same value.
REQ-027 Cp SHALL increment PC at the rising edge, wrapping 4'hF -> 4'h0; Ep and Cp together SHALL drive the pre-increment PC.
REQ-028 A register both driving and loading in one cycle SHALL reload its own value.
REQ-029 Prog_we=1 SHALL write Prog_data to RAM[Prog_addr] at the rising edge, regardless of Clr; a same-cycle CEbar read of that address SHALL return the old data.
REQ-030 opcode SHALL equal IR[7:4]; Out_port SHALL equal OUT; both registered, no combinational path from inputs.

Reset
REQ-031 Clr=1 at a rising edge SHALL set PC=PC_RESET, MAR=0, IR=0, A=0, B=0, OUT=0 (hence opcode=4'h0, Out_port=8'h00) and override Cp and all loads that cycle.
REQ-032 RAM contents SHALL NOT be altered by Clr; W_bus and Bus_conflict remain combinational during reset.

Configuration
REQ-033 Macro SAP_1_DATAPATH_FLAGS_EN defined: outputs Carry and Zero (1 bit each) SHALL be added, registered when LAbar=0 and EU=1 (Carry = adder bit 8, Zero = result==0), cleared by Clr; undefined: ports and flag logic SHALL be absent.

Verification
REQ-034 Clr=1 one cycle, then Clr=0 -> PC=0, A=0, Out_port=8'h00, opcode=4'h0.
REQ-035 Program RAM[0]=8'h09, then Ep+LMbar=0, next CEbar=0+LIbar=0 -> opcode=4'h0, IR[3:0]=4'h9 next cycle.
REQ-036 A=8'h05, B=8'h03, SU=1, EU=1, LAbar=0 -> A=8'h02; repeat SU=0 with A=8'hFF, B=8'h01 -> A=8'h00 (Carry=1, Zero=1 when flags enabled).
REQ-037 Cp held 17 cycles from PC=0 -> PC=4'h1 (wrap through 4'hF -> 4'h0).
REQ-038 Ep=1 and EA=1 same cycle with PC=4'h3, A=8'hAA -> W_bus=8'h03, Bus_conflict=1.
